// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync word, then the payload MSB first, then an idle gap, one bit per clock.
// Latency: first sync bit appears one cycle after the handshake edge; last payload bit 8+PAYLOAD_W cycles after it.
// Backpressure: data_ready is high only in IDLE; data_valid offered while busy is ignored and data_in is not sampled.
module seq_frame_tx #(
    parameter logic [7:0] SYNC_PATTERN = 8'b1011_0001,
    parameter int         PAYLOAD_W    = 8,
    parameter int         GAP_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_valid,
    input  logic [PAYLOAD_W-1:0] data_in,
    output logic                 data_ready,
    output logic                 seq_out,
    output logic                 seq_out_valid,
    output logic                 busy,
    output logic                 frame_done
);

    // The counter must also reach the last gap bit, so GAP_CYCLES joins the sizing.
    localparam int CNT_N = (PAYLOAD_W > 8) ?
                           ((PAYLOAD_W > GAP_CYCLES) ? PAYLOAD_W : GAP_CYCLES) :
                           ((GAP_CYCLES > 8) ? GAP_CYCLES : 8);
    localparam int CW = $clog2(CNT_N);

    localparam logic [CW-1:0] SYNC_LAST = CW'(7);
    localparam logic [CW-1:0] PAY_LAST  = CW'(PAYLOAD_W - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [PAYLOAD_W-1:0] shreg, shreg_nxt;
    logic                 out_nxt, out_vld_nxt, busy_nxt, done_nxt;

    assign data_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            shreg         <= '0;
            seq_out       <= 1'b0;
            seq_out_valid <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            shreg         <= shreg_nxt;
            seq_out       <= out_nxt;
            seq_out_valid <= out_vld_nxt;
            busy          <= busy_nxt;
            frame_done    <= done_nxt;
        end
    end

    // Outputs are computed from the current state and registered, so the line lags the state by one cycle.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        out_nxt     = 1'b0;
        out_vld_nxt = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (data_valid) begin
                    state_nxt = SYNC;
                    cnt_nxt   = '0;
                    shreg_nxt = data_in;
                end
            end
            SYNC: begin
                out_nxt     = SYNC_PATTERN[3'd7 - cnt[2:0]];
                out_vld_nxt = 1'b1;
                busy_nxt    = 1'b1;
                if (cnt == SYNC_LAST) begin
                    state_nxt = PAYLOAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PAYLOAD: begin
                out_nxt     = shreg[PAYLOAD_W-1];
                shreg_nxt   = shreg << 1;
                out_vld_nxt = 1'b1;
                busy_nxt    = 1'b1;
                if (cnt == PAY_LAST) begin
                    done_nxt  = 1'b1;
                    state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            GAP: begin
                busy_nxt = 1'b1;
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: default build (8-bit payload, 2-cycle gap) plus a 4-bit/no-gap build.
// Outputs are sampled on the falling edge; index k counts rising edges after the handshake edge.
module tb_seq_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_valid = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       a_ready, a_out, a_ovld, a_busy, a_done;

    logic       b_valid = 1'b0;
    logic [3:0] b_data = 4'h0;
    logic       b_ready, b_out, b_ovld, b_busy, b_done;

    seq_frame_tx u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_valid    (a_valid),
        .data_in       (a_data),
        .data_ready    (a_ready),
        .seq_out       (a_out),
        .seq_out_valid (a_ovld),
        .busy          (a_busy),
        .frame_done    (a_done)
    );

    seq_frame_tx #(.PAYLOAD_W(4), .GAP_CYCLES(0)) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_valid    (b_valid),
        .data_in       (b_data),
        .data_ready    (b_ready),
        .seq_out       (b_out),
        .seq_out_valid (b_ovld),
        .busy          (b_busy),
        .frame_done    (b_done)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;

    logic obs_out  [0:63];
    logic obs_vld  [0:63];
    logic obs_rdy  [0:63];
    logic obs_busy [0:63];
    int   cnt_vld, cnt_done, cnt_busy, cnt_rdy_low, first_vld_k, last_done_k;
    logic [7:0] det_win;
    int   n_det;
    int   det_k [0:7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cnt_vld = 0; cnt_done = 0; cnt_busy = 0; cnt_rdy_low = 0;
        first_vld_k = -1; last_done_k = -1;
        det_win = 8'h00; n_det = 0;
    endtask

    // Records one sample; the window is a behavioural model of the downstream sync detector.
    task automatic sample(input int k, input bit sel);
        logic o, v, r, b, d;
        o = sel ? b_out  : a_out;
        v = sel ? b_ovld : a_ovld;
        r = sel ? b_ready : a_ready;
        b = sel ? b_busy : a_busy;
        d = sel ? b_done : a_done;
        obs_out[k] = o; obs_vld[k] = v; obs_rdy[k] = r; obs_busy[k] = b;
        if (v) begin
            cnt_vld++;
            if (first_vld_k < 0) first_vld_k = k;
        end
        if (d) begin
            cnt_done++;
            last_done_k = k;
        end
        if (b) cnt_busy++;
        if (!r) cnt_rdy_low++;
        det_win = {det_win[6:0], o};
        if (det_win == 8'hB1 && n_det < 8) begin
            det_k[n_det] = k;
            n_det++;
        end
    endtask

    function automatic logic [31:0] word_of(input int from, input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w = {w[30:0], obs_out[from + i]};
        return w;
    endfunction

    task automatic wait_ready(input bit sel, input string tag);
        int t;
        t = 0;
        while (!(sel ? b_ready : a_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(tag, {31'd0, (sel ? b_ready : a_ready)}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_seq_out", {31'd0, a_out}, 32'd0);
        check("rst_out_valid", {31'd0, a_ovld}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_frame_done", {31'd0, a_done}, 32'd0);
        check("rst_ready_a", {31'd0, a_ready}, 32'd1);
        check("rst_ready_b", {31'd0, b_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame, payload 5A; data_in changes after the handshake must not matter
        clear_stats();
        a_data = 8'h5A; a_valid = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            sample(k, 1'b0);
            if (k == 0) begin a_valid = 1'b0; a_data = 8'hFF; end
        end
        check("t1_bits", word_of(1, 16), 32'hB15A);
        check("t1_vld_cnt", cnt_vld, 16);
        check("t1_first_vld", first_vld_k, 1);
        check("t1_done_cnt", cnt_done, 1);
        check("t1_done_pos", last_done_k, 16);
        check("t1_rdy_low", cnt_rdy_low, 18);
        check("t1_rdy_back", {31'd0, obs_rdy[18]}, 32'd1);
        check("t1_busy_cnt", cnt_busy, 18);
        check("t1_gap_zero", word_of(17, 4), 32'h0);

        // Back-to-back frames with data_valid held: 00 then FF, 19 cycles apart
        wait_ready(1'b0, "t2_idle");
        clear_stats();
        a_data = 8'h00; a_valid = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            sample(k, 1'b0);
            if (k == 0) a_data = 8'hFF;
            if (k == 19) begin a_valid = 1'b0; a_data = 8'h0F; end
        end
        check("t2_bits_f1", word_of(1, 16), 32'hB100);
        check("t2_bits_f2", word_of(20, 16), 32'hB1FF);
        check("t2_rdy_k18", {31'd0, obs_rdy[18]}, 32'd1);
        check("t2_rdy_k19", {31'd0, obs_rdy[19]}, 32'd0);
        check("t2_done_cnt", cnt_done, 2);
        check("t2_done_pos", last_done_k, 35);
        check("t2_vld_cnt", cnt_vld, 32);
        check("t2_rdy_k37", {31'd0, obs_rdy[37]}, 32'd1);
        check("t2_no_third", {31'd0, obs_vld[39]}, 32'd0);

        // 4-bit payload, no gap: one IDLE cycle between frames
        wait_ready(1'b1, "t3_idle");
        clear_stats();
        b_data = 4'h9; b_valid = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            sample(k, 1'b1);
            if (k == 13) b_valid = 1'b0;
        end
        check("t3_bits", word_of(1, 12), 32'hB19);
        check("t3_done_cnt", cnt_done, 1);
        check("t3_done_pos", last_done_k, 12);
        check("t3_rdy_k11", {31'd0, obs_rdy[11]}, 32'd0);
        check("t3_rdy_k12", {31'd0, obs_rdy[12]}, 32'd1);
        check("t3_rdy_k13", {31'd0, obs_rdy[13]}, 32'd0);
        check("t3_idle_vld", {31'd0, obs_vld[13]}, 32'd0);
        check("t3_next_vld", {31'd0, obs_vld[14]}, 32'd1);
        check("t3_next_bit", {31'd0, obs_out[14]}, 32'd1);
        wait_ready(1'b1, "t3_drain");

        // Reset asserted mid-payload
        wait_ready(1'b0, "t4_idle");
        clear_stats();
        a_data = 8'hC3; a_valid = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            sample(k, 1'b0);
            if (k == 0) a_valid = 1'b0;
        end
        check("t4_busy_pre", {31'd0, obs_busy[11]}, 32'd1);
        check("t4_vld_pre", {31'd0, obs_vld[11]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t4_rst_out", {31'd0, a_out}, 32'd0);
        check("t4_rst_vld", {31'd0, a_ovld}, 32'd0);
        check("t4_rst_busy", {31'd0, a_busy}, 32'd0);
        check("t4_rst_done", {31'd0, a_done}, 32'd0);
        check("t4_rst_ready", {31'd0, a_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            sample(k, 1'b0);
        end
        check("t4_no_done", cnt_done, 0);
        check("t4_no_resume", cnt_vld, 0);
        clear_stats();
        a_data = 8'h96; a_valid = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            sample(k, 1'b0);
            if (k == 0) a_valid = 1'b0;
        end
        check("t4_bits", word_of(1, 16), 32'hB196);
        check("t4_done_pos", last_done_k, 16);

        // Loopback into a detector model: 00, 3C, B1
        wait_ready(1'b0, "t5_idle");
        clear_stats();
        a_data = 8'h00; a_valid = 1'b1;
        for (int k = 0; k <= 60; k++) begin
            @(negedge clk);
            sample(k, 1'b0);
            if (k == 0) a_data = 8'h3C;
            if (k == 19) a_data = 8'hB1;
            if (k == 38) a_valid = 1'b0;
        end
        check("t5_det_cnt", n_det, 4);
        check("t5_det0", det_k[0], 8);
        check("t5_det1", det_k[1], 27);
        check("t5_det2", det_k[2], 46);
        check("t5_det3", det_k[3], 54);
        check("t5_bits_f3", word_of(39, 16), 32'hB1B1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
